// File: rtl/if_fetch_pipe.sv
// Instruction-fetch stage: PC register, boot/run/hold FSM and IF/ID latch with stall, flush and redirect.
// Optional stall/squash event counters are built when FETCH_PERF_CNT_EN is defined.
module if_fetch_pipe #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_incr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_out,
  output logic [31:0] ifid_npc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic [1:0]  fetch_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] squash_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_p0;
  logic [31:0] npc_p1;
  logic [31:0] instr_p1;
  logic        vld_p1;
  logic        squash;

  assign squash = flush | branch_taken;

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = (branch_taken || !stall) ? RUN : HOLD;
      RUN:     state_nxt = (stall && !branch_taken) ? HOLD : RUN;
      HOLD:    state_nxt = (!stall || branch_taken) ? RUN : HOLD;
      default: state_nxt = BOOT;
    endcase
  end

  // Stage 0: program counter; a redirect beats a stall.
  always_ff @(posedge clk) begin
    if (rst)               pc_p0 <= RESET_PC;
    else if (branch_taken) pc_p0 <= branch_target;
    else if (!stall)       pc_p0 <= pc_incr;
  end

  // Stage 1: IF/ID latch; a squash still lands while stalled so the hazard unit cannot keep a dead instruction.
  always_ff @(posedge clk) begin
    if (rst || squash) begin
      npc_p1   <= 32'd0;
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
    end else if (!stall) begin
      npc_p1   <= pc_incr;
      instr_p1 <= imem_rdata;
      vld_p1   <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= 32'd0;
      squash_cnt <= 32'd0;
    end else begin
      if (stall && !branch_taken) stall_cnt <= stall_cnt + 32'd1;
      if (squash)                 squash_cnt <= squash_cnt + 32'd1;
    end
  end
`endif

  assign pc_out      = pc_p0;
  assign ifid_npc    = npc_p1;
  assign ifid_instr  = instr_p1;
  assign ifid_valid  = vld_p1;
  assign fetch_state = state;

endmodule

// File: tb/tb_if_fetch_pipe.sv
// Bench for if_fetch_pipe: directed scenarios followed by random control traffic against a cycle-level model.
module tb_if_fetch_pipe;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, flush, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc_incr, imem_rdata;
  logic [31:0] pc_out, ifid_npc, ifid_instr;
  logic        ifid_valid;
  logic [1:0]  fetch_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt, squash_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // model of the architecturally visible state
  logic [31:0] m_pc, m_npc, m_instr, m_sc, m_qc;
  logic        m_valid;
  logic [1:0]  m_state;

  always #5 clk = ~clk;

  assign pc_incr    = pc_out + 32'd1;
  assign imem_rdata = pc_out ^ 32'hA5A5_0000;

  if_fetch_pipe #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .pc_incr(pc_incr), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_out(pc_out), .ifid_npc(ifid_npc),
    .ifid_instr(ifid_instr), .ifid_valid(ifid_valid), .fetch_state(fetch_state)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("pc", pc_out, m_pc);
    chk("npc", ifid_npc, m_npc);
    chk("instr", ifid_instr, m_instr);
    chk("valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    chk("state", {30'd0, fetch_state}, {30'd0, m_state});
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_sc);
    chk("squash_cnt", squash_cnt, m_qc);
`endif
  endtask

  // Apply one cycle of inputs, advance the model by the fetch rules, then compare after the edge.
  task automatic step(input logic s, input logic f, input logic b,
                      input logic [31:0] t, input logic r);
    logic [31:0] inc;
    stall = s; flush = f; branch_taken = b; branch_target = t; rst = r;
    inc = m_pc + 32'd1;
    if (r) begin
      m_pc = RESET_PC; m_npc = 32'd0; m_instr = NOP_INSTR; m_valid = 1'b0;
      m_state = 2'd0; m_sc = 32'd0; m_qc = 32'd0;
    end else begin
      if (m_state == 2'd0)      m_state = (b || !s) ? 2'd1 : 2'd2;
      else if (m_state == 2'd1) m_state = (s && !b) ? 2'd2 : 2'd1;
      else                      m_state = (!s || b) ? 2'd1 : 2'd2;
      if (s && !b) m_sc = m_sc + 32'd1;
      if (f || b) begin
        m_qc = m_qc + 32'd1;
        m_npc = 32'd0; m_instr = NOP_INSTR; m_valid = 1'b0;
      end else if (!s) begin
        m_npc = inc; m_instr = m_pc ^ 32'hA5A5_0000; m_valid = 1'b1;
      end
      if (b)       m_pc = t;
      else if (!s) m_pc = inc;
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    stall = 0; flush = 0; branch_taken = 0; branch_target = 0; rst = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_pc", pc_out, RESET_PC);
    chk("rst_instr", ifid_instr, NOP_INSTR);

    // free run
    step(0, 0, 0, 0, 0);
    chk("run_pc1", pc_out, 32'd1);
    chk("run_instr", ifid_instr, 32'hA5A5_0000);
    chk("run_npc", ifid_npc, 32'd1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("run_pc3", pc_out, 32'd3);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // stall at PC 5
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      chk("stall_pc", pc_out, 32'd5);
      chk("stall_npc", ifid_npc, 32'd5);
      chk("stall_state", {30'd0, fetch_state}, 32'd2);
    end
    step(0, 0, 0, 0, 0);
    chk("release_pc", pc_out, 32'd6);
    step(0, 0, 0, 0, 0);
    // branch at PC 7 concurrent with stall
    step(1, 0, 1, 32'h40, 0);
    chk("br_pc", pc_out, 32'h40);
    chk("br_valid", {31'd0, ifid_valid}, 32'd0);
    step(0, 0, 0, 0, 0);
    chk("br_npc", ifid_npc, 32'h41);
    chk("br_valid2", {31'd0, ifid_valid}, 32'd1);
    // flush with stall
    step(1, 1, 0, 0, 0);
    chk("fl_pc", pc_out, 32'h41);
    chk("fl_instr", ifid_instr, NOP_INSTR);
    // wrap
    step(0, 0, 1, 32'hFFFF_FFFF, 0);
    step(0, 0, 0, 0, 0);
    chk("wrap_pc", pc_out, 32'd0);
    chk("wrap_npc", ifid_npc, 32'd0);
    chk("wrap_valid", {31'd0, ifid_valid}, 32'd1);
    // reset mid-run at PC 0x12
    step(0, 0, 1, 32'h12, 0);
    step(0, 0, 0, 0, 1);
    chk("mrst_pc", pc_out, RESET_PC);
    chk("mrst_state", {30'd0, fetch_state}, 32'd0);
    // branch out of BOOT
    step(1, 0, 1, 32'h80, 0);
    chk("boot_br_state", {30'd0, fetch_state}, 32'd1);
    step(0, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 99) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
